dcache_mgmt_ctrl: RTL and testbench
===================================

Name: dcache_mgmt_ctrl

Overview:
- Initiator (driver) side of the dcache management port. Sits between the CSR/fence logic and the std cache subsystem.
- Drives dcache_enable/dcache_flush and holds flush high until the cache acknowledges.
- Drains the write buffer before flushing and stalls new core requests while a flush is in progress.
- Keeps miss and flush-latency performance counters.

Parameters:
- CNT_W, 32, width of miss_cnt_o and flush_cyc_o.
- AUTO_FLUSH_ON_DISABLE, 1, if 1 a 1->0 edge on en_csr_i flushes before dcache_enable_o drops.
- TIMEOUT_CYCLES, 4096, flush watchdog limit (used only with FLUSH_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_csr_i  in  1  cache enable from CSR
- flush_req_i  in  1  flush request from fence logic, one-cycle pulse
- miss_cnt_clr_i  in  1  clear miss counter
- flush_done_o  out  1  one-cycle pulse when a flush completes
- busy_o  out  1  FSM not in IDLE
- stall_o  out  1  block new dcache requests from the core
- dcache_enable_o  out  1  to cache
- dcache_flush_o  out  1  to cache, held high until ack
- dcache_flushing_i  in  1  cache has started flushing
- dcache_flush_ack_i  in  1  cache single-cycle flush ack
- dcache_miss_i  in  1  cache miss pulse
- wbuffer_empty_i  in  1  write buffer empty
- miss_cnt_o  out  CNT_W  saturating miss count
- flush_cyc_o  out  CNT_W  cycle length of the last completed flush
- timeout_o  out  1  sticky flush watchdog flag

Behaviour:
- Reset (async, rst_ni=0):
  - FSM=IDLE, pending=0.
  - All outputs 0: dcache_enable_o, dcache_flush_o, flush_done_o, busy_o, stall_o, timeout_o, miss_cnt_o, flush_cyc_o.
  - Reset mid-flush abandons the flush immediately, with no done pulse.
- All outputs are registered.
- FSM states: IDLE, DRAIN, FLUSH, DONE.
- IDLE:
  - dcache_enable_o <= en_csr_i, except that a 1->0 edge with AUTO_FLUSH_ON_DISABLE=1 keeps enable=1 and goes to DRAIN with disable_after=1.
  - flush_req_i or pending -> DRAIN; pending cleared.
- DRAIN:
  - stall_o=1.
  - Waits for wbuffer_empty_i=1, then -> FLUSH on the next cycle.
  - If wbuffer_empty_i is already 1 on entry, still spend exactly 1 cycle in DRAIN.
  - flush_req_i arriving in DRAIN is absorbed (coalesced).
- FLUSH:
  - dcache_flush_o=1, stall_o=1.
  - flush cycle counter starts at 1 on entry and increments each cycle, saturating at 2^CNT_W-1.
  - dcache_flush_ack_i=1 -> DONE; dcache_flush_o deasserts the following cycle.
  - The counted value, inclusive of the ack cycle, is latched into flush_cyc_o.
  - dcache_flushing_i is informational only and has no effect on transitions.
- DONE:
  - flush_done_o=1 for exactly one cycle, stall_o=1.
  - If disable_after is set, dcache_enable_o <= 0 this cycle.
  - Then -> IDLE.
- Requests arriving in FLUSH or DONE set pending; they trigger exactly one further flush and are never dropped.
- Ack outside FLUSH is ignored.
- Minimum flush latency, request to done pulse: DRAIN 1, FLUSH >=1, DONE 1 cycles.
- busy_o = (state != IDLE).
- en_csr_i changes while busy are ignored until IDLE; the value is sampled in IDLE.
- miss_cnt_o:
  - +1 per cycle with dcache_miss_i=1, saturating.
  - miss_cnt_clr_i has priority over increment: clear and a miss in the same cycle -> 0.

Optional Feature:
- Macro: FLUSH_TIMEOUT_EN.
- Defined:
  - If FLUSH lasts TIMEOUT_CYCLES cycles without ack, the FSM deasserts dcache_flush_o and goes to DONE, which pulses flush_done_o.
  - timeout_o is set and stays sticky until the next flush_req_i is accepted in IDLE.
  - An ack arriving in the same cycle as expiry counts as a normal completion, with no timeout.
- Not defined: no watchdog, timeout_o tied 0, and FLUSH waits indefinitely.

Test Plan:
- Reset with en_csr_i=1 -> all outputs 0; dcache_enable_o=1 two cycles after rst_ni rises.
- flush_req_i pulse, wbuffer_empty_i=1, ack 5 cycles after flush asserts -> dcache_flush_o high 6 cycles, flush_cyc_o=6, single flush_done_o pulse, stall_o low after DONE.
- wbuffer_empty_i=0 for 10 cycles after the request -> dcache_flush_o stays 0 until 1 cycle after empty; second flush_req_i during DRAIN -> only one flush.
- flush_req_i during FLUSH -> after DONE a second DRAIN/FLUSH sequence runs, giving exactly two flush_done_o pulses.
- en_csr_i 1->0 with AUTO_FLUSH_ON_DISABLE=1 -> full flush runs and dcache_enable_o falls in the DONE cycle; 3 miss pulses plus clear coincident with the 3rd -> miss_cnt_o=0.
- FLUSH_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no ack -> dcache_flush_o drops after 16 cycles, flush_done_o pulses, timeout_o=1 until the next request.

Source files
------------

// File: rtl/dcache_mgmt_ctrl.sv
// Initiator side of the dcache management port: enable/flush sequencing, write-buffer drain,
// core stall during flush, miss and flush-latency counters. Optional watchdog: FLUSH_TIMEOUT_EN.
module dcache_mgmt_ctrl #(
  parameter int CNT_W                 = 32,
  parameter bit AUTO_FLUSH_ON_DISABLE = 1'b1,
  parameter int TIMEOUT_CYCLES        = 4096
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_csr_i,
  input  logic             flush_req_i,
  input  logic             miss_cnt_clr_i,
  output logic             flush_done_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             dcache_enable_o,
  output logic             dcache_flush_o,
  input  logic             dcache_flushing_i,
  input  logic             dcache_flush_ack_i,
  input  logic             dcache_miss_i,
  input  logic             wbuffer_empty_i,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] flush_cyc_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  logic             r_pending;
  logic             r_disable_after;
  logic [CNT_W-1:0] r_fcnt;

  logic w_dis_edge;
  logic w_start;
  logic w_to_hit;
  logic w_expire;
  logic w_unused;

  // Enable output doubles as the previous CSR value, so a disable seen late (after busy) still flushes.
  assign w_dis_edge = AUTO_FLUSH_ON_DISABLE && dcache_enable_o && !en_csr_i;
  assign w_start    = flush_req_i || r_pending || w_dis_edge;
  assign w_to_hit   = (r_fcnt == TO_LIM);

`ifdef FLUSH_TIMEOUT_EN
  assign w_expire = w_to_hit;
`else
  assign w_expire = 1'b0;
`endif

  assign w_unused = ^{dcache_flushing_i, w_to_hit};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= IDLE;
      r_pending       <= 1'b0;
      r_disable_after <= 1'b0;
      r_fcnt          <= '0;
      flush_done_o    <= 1'b0;
      busy_o          <= 1'b0;
      stall_o         <= 1'b0;
      dcache_enable_o <= 1'b0;
      dcache_flush_o  <= 1'b0;
      miss_cnt_o      <= '0;
      flush_cyc_o     <= '0;
      timeout_o       <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;

      if (miss_cnt_clr_i) begin
        miss_cnt_o <= '0;
      end else if (dcache_miss_i && (miss_cnt_o != CNT_MAX)) begin
        miss_cnt_o <= miss_cnt_o + 1'b1;
      end

      if (flush_req_i && ((r_state == FLUSH) || (r_state == DONE))) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          dcache_enable_o <= w_dis_edge ? 1'b1 : en_csr_i;
          if (w_start) begin
            r_state         <= DRAIN;
            busy_o          <= 1'b1;
            stall_o         <= 1'b1;
            r_pending       <= 1'b0;
            r_disable_after <= w_dis_edge;
            if (flush_req_i || r_pending) begin
              timeout_o <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (wbuffer_empty_i) begin
            r_state        <= FLUSH;
            dcache_flush_o <= 1'b1;
            r_fcnt         <= CNT_W'(1);
          end
        end
        FLUSH: begin
          // An ack in the expiry cycle wins: it is a normal completion.
          if (dcache_flush_ack_i || w_expire) begin
            r_state        <= DONE;
            dcache_flush_o <= 1'b0;
            flush_cyc_o    <= r_fcnt;
            flush_done_o   <= 1'b1;
            if (!dcache_flush_ack_i) begin
              timeout_o <= 1'b1;
            end
            if (r_disable_after) begin
              dcache_enable_o <= 1'b0;
            end
          end else if (r_fcnt != CNT_MAX) begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        DONE: begin
          r_state         <= IDLE;
          busy_o          <= 1'b0;
          stall_o         <= 1'b0;
          r_disable_after <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mgmt_ctrl.sv
// Self-checking bench for dcache_mgmt_ctrl: vector table of drain/ack timings, random timings
// checked against closed-form latency rules, hand sequences for coalescing, pending, disable, reset.
module tb_dcache_mgmt_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_csr_i = 1'b0;
  logic        flush_req_i = 1'b0;
  logic        miss_cnt_clr_i = 1'b0;
  logic        flush_done_o;
  logic        busy_o;
  logic        stall_o;
  logic        dcache_enable_o;
  logic        dcache_flush_o;
  logic        dcache_flushing_i = 1'b0;
  logic        dcache_flush_ack_i = 1'b0;
  logic        dcache_miss_i = 1'b0;
  logic        wbuffer_empty_i = 1'b1;
  logic [31:0] miss_cnt_o;
  logic [31:0] flush_cyc_o;
  logic        timeout_o;

  dcache_mgmt_ctrl #(.CNT_W(32), .AUTO_FLUSH_ON_DISABLE(1'b1), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_csr_i(en_csr_i), .flush_req_i(flush_req_i),
    .miss_cnt_clr_i(miss_cnt_clr_i), .flush_done_o(flush_done_o), .busy_o(busy_o),
    .stall_o(stall_o), .dcache_enable_o(dcache_enable_o), .dcache_flush_o(dcache_flush_o),
    .dcache_flushing_i(dcache_flushing_i), .dcache_flush_ack_i(dcache_flush_ack_i),
    .dcache_miss_i(dcache_miss_i), .wbuffer_empty_i(wbuffer_empty_i),
    .miss_cnt_o(miss_cnt_o), .flush_cyc_o(flush_cyc_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int d;          // cycles wbuffer stays non-empty after the request
    int a;          // cycles from flush assertion to ack
    int exp_hi;     // cycles dcache_flush_o is high
    int exp_cyc;    // flush_cyc_o
    int exp_done_t; // cycle index of the done pulse
  } vec_t;

  vec_t vecs[5];

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_model = '0;
  bit          rnd_miss = 1'b0;

  int hi_cnt, rise_cnt, done_cnt, done_t, first_hi_t;
  bit en_hist[64];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: advance the miss reference, sample outputs #1 after the edge, re-randomize miss inputs.
  task automatic cyc();
    logic [31:0] m_next;
    if (miss_cnt_clr_i) m_next = '0;
    else if (dcache_miss_i && m_model != 32'hFFFF_FFFF) m_next = m_model + 1;
    else m_next = m_model;
    @(posedge clk_i);
    #1;
    m_model = m_next;
    chk("miss_cnt", miss_cnt_o, m_model);
    if (rnd_miss) begin
      dcache_miss_i  = ($urandom % 3) == 0;
      miss_cnt_clr_i = ($urandom % 9) == 0;
    end else begin
      dcache_miss_i  = 1'b0;
      miss_cnt_clr_i = 1'b0;
    end
  endtask

  // Cycle t: inputs set before edge t, outputs observed after it. Request at t=0,
  // buffer empty from t=d+1, ack at t=d+a+2 (plus optionally held from ack_from).
  task automatic run_seq(input int d, input int a, input int n, input int req2_t,
                         input int ack_from, input bit do_req);
    bit prev = 1'b0;
    hi_cnt = 0; rise_cnt = 0; done_cnt = 0; done_t = -1; first_hi_t = -1;
    for (int t = 0; t < n; t++) begin
      flush_req_i        = (do_req && t == 0) || (t == req2_t);
      wbuffer_empty_i    = (t >= d + 1);
      dcache_flush_ack_i = (t == d + a + 2) || (ack_from >= 0 && t >= ack_from);
      dcache_flushing_i  = dcache_flush_o;
      cyc();
      if (dcache_flush_o) begin
        hi_cnt++;
        if (first_hi_t < 0) first_hi_t = t;
      end
      if (dcache_flush_o && !prev) rise_cnt++;
      prev = dcache_flush_o;
      if (flush_done_o) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (t < 64) en_hist[t] = dcache_enable_o;
    end
    flush_req_i = 1'b0; dcache_flush_ack_i = 1'b0; wbuffer_empty_i = 1'b1; dcache_flushing_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{d: 0,  a: 0, exp_hi: 1,  exp_cyc: 1,  exp_done_t: 2};
    vecs[1] = '{d: 0,  a: 5, exp_hi: 6,  exp_cyc: 6,  exp_done_t: 7};
    vecs[2] = '{d: 10, a: 0, exp_hi: 1,  exp_cyc: 1,  exp_done_t: 12};
    vecs[3] = '{d: 3,  a: 2, exp_hi: 3,  exp_cyc: 3,  exp_done_t: 7};
    vecs[4] = '{d: 2,  a: 9, exp_hi: 10, exp_cyc: 10, exp_done_t: 13};

    // Reset with the CSR enable already high.
    en_csr_i = 1'b1;
    #12;
    chk("rst_enable", dcache_enable_o, 0);
    chk("rst_flush", dcache_flush_o, 0);
    chk("rst_done", flush_done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_miss", miss_cnt_o, 0);
    chk("rst_cyc", flush_cyc_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc();
    cyc();
    chk("enable_after_rst", dcache_enable_o, 1);

    // Ack outside FLUSH has no effect.
    dcache_flush_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    dcache_flush_ack_i = 1'b0;
    chk("ack_idle_busy", busy_o, 0);
    chk("ack_idle_done", flush_done_o, 0);

    // Miss counter: clear coincident with the third miss wins.
    miss_cnt_clr_i = 1'b1;
    cyc();
    chk("miss_clr", miss_cnt_o, 0);
    dcache_miss_i = 1'b1; cyc();
    dcache_miss_i = 1'b1; cyc();
    chk("miss_two", miss_cnt_o, 2);
    dcache_miss_i = 1'b1; miss_cnt_clr_i = 1'b1; cyc();
    chk("miss_clr_prio", miss_cnt_o, 0);

    // Vector table.
    rnd_miss = 1'b1;
    foreach (vecs[i]) begin
      run_seq(vecs[i].d, vecs[i].a, vecs[i].d + vecs[i].a + 6, -1, -1, 1'b1);
      chk($sformatf("vec%0d_flush_hi", i), hi_cnt, vecs[i].exp_hi);
      chk($sformatf("vec%0d_flush_cyc", i), flush_cyc_o, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_done_t", i), done_t, vecs[i].exp_done_t);
      chk($sformatf("vec%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("vec%0d_stall_end", i), stall_o, 0);
      chk($sformatf("vec%0d_busy_end", i), busy_o, 0);
    end

    // Random drain/ack timings against the latency rules.
    for (int k = 0; k < 8; k++) begin
      int d, a;
      d = $urandom_range(0, 6);
      a = $urandom_range(0, 8);
      run_seq(d, a, d + a + 6, -1, -1, 1'b1);
      chk("rnd_flush_hi", hi_cnt, a + 1);
      chk("rnd_flush_cyc", flush_cyc_o, a + 1);
      chk("rnd_first_hi", first_hi_t, d + 1);
      chk("rnd_done_t", done_t, d + a + 2);
      chk("rnd_done_cnt", done_cnt, 1);
    end

    // Second request during DRAIN is coalesced into the same flush.
    run_seq(10, 0, 18, 4, -1, 1'b1);
    chk("coal_first_hi", first_hi_t, 11);
    chk("coal_rises", rise_cnt, 1);
    chk("coal_done_cnt", done_cnt, 1);

    // Request during FLUSH leaves one pending flush that runs afterwards.
    run_seq(0, 2, 14, 2, 8, 1'b1);
    chk("pend_rises", rise_cnt, 2);
    chk("pend_done_cnt", done_cnt, 2);
    chk("pend_busy_end", busy_o, 0);

    // CSR disable: flush runs first, enable drops in the DONE cycle and stays low.
    en_csr_i = 1'b0;
    run_seq(0, 1, 8, -1, -1, 1'b0);
    chk("dis_done_t", done_t, 3);
    chk("dis_done_cnt", done_cnt, 1);
    chk("dis_en_before_done", en_hist[2], 1);
    chk("dis_en_at_done", en_hist[3], 0);
    chk("dis_en_end", en_hist[7], 0);

`ifdef FLUSH_TIMEOUT_EN
    // Watchdog: no ack, flush abandoned after 16 cycles, sticky flag until next request.
    run_seq(0, 100, 22, -1, -1, 1'b1);
    chk("to_flush_hi", hi_cnt, 16);
    chk("to_done_t", done_t, 17);
    chk("to_flag", timeout_o, 1);
    run_seq(0, 0, 5, -1, -1, 1'b1);
    chk("to_flag_clr", timeout_o, 0);
`else
    chk("timeout_tied", timeout_o, 0);
`endif

    // Reset in the middle of a flush abandons it with no done pulse.
    rnd_miss = 1'b0;
    en_csr_i = 1'b1;
    flush_req_i = 1'b1; wbuffer_empty_i = 1'b1; cyc();
    flush_req_i = 1'b0; cyc(); cyc();
    chk("mid_flush_active", dcache_flush_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    m_model = '0;
    chk("mid_rst_flush", dcache_flush_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (flush_done_o) done_cnt++;
    end
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
